// File: rtl/qq_pkg.sv
// -----------------------------------------------------------------------------
// qq_pkg: shared types and constants for the Quick Priority Queue fill path.
//   fill_state_t : fill sequencer state encoding
//   KW_DEF/AW_DEF: default key width / lower-level store address width
//   FILL_N       : number of top-bank slots written per fill burst
// -----------------------------------------------------------------------------
package qq_pkg;

    localparam int KW_DEF = 16;
    localparam int AW_DEF = 8;
    localparam int FILL_N = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5
    } fill_state_t;

endpackage

// File: rtl/qq_fill_ctrl_if.sv
// -----------------------------------------------------------------------------
// qq_fill_ctrl_if: bundles the requester, lower-level store, top-bank and
// fill-counter signals of the fill sequencer.
//   modport master : the fill sequencer (drives ack/done, rd_*, wr_*, fill_*)
//   modport slave  : the environment (requester, key store, bank, counter)
//
// Handshakes:
//   fill_req is held high until fill_ack (a one-cycle pulse); fill_base is
//   sampled in the fill_ack cycle. fill_done is a one-cycle pulse and
//   fill_short/fill_err are only meaningful in that cycle. rd_en is a
//   one-cycle strobe; rd_valid answers it one or more cycles later, with
//   rd_empty/rd_data valid in the rd_valid cycle only.
// -----------------------------------------------------------------------------
interface qq_fill_ctrl_if
    import qq_pkg::*;
#(
    parameter int KW     = KW_DEF,
    parameter int AW     = AW_DEF,
    parameter int SLOT_W = 2
);
    logic              fill_req;
    logic [AW-1:0]     fill_base;
    logic              fill_ack;
    logic              fill_done;
    logic              fill_short;
    logic              fill_err;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic              rd_valid;
    logic              rd_empty;
    logic [KW-1:0]     rd_data;
    logic              wr_en;
    logic [SLOT_W-1:0] wr_slot;
    logic [KW-1:0]     wr_data;
    logic              fill_cnt;
    logic              fill_rst;
    logic              cnt_done;

    modport master (
        input  fill_req, fill_base, rd_valid, rd_empty, rd_data, cnt_done,
        output fill_ack, fill_done, fill_short, fill_err, rd_en, rd_addr,
               wr_en, wr_slot, wr_data, fill_cnt, fill_rst
    );

    modport slave (
        output fill_req, fill_base, rd_valid, rd_empty, rd_data, cnt_done,
        input  fill_ack, fill_done, fill_short, fill_err, rd_en, rd_addr,
               wr_en, wr_slot, wr_data, fill_cnt, fill_rst
    );
endinterface

// File: rtl/qq_fill_wdog.sv
// -----------------------------------------------------------------------------
// qq_fill_wdog: read-wait watchdog for the fill sequencer (used only when
// QQ_FILL_TIMEOUT_EN is defined).
//   clk, rst  : clock, async active-high reset
//   i_clr     : clear the cycle count (asserted the cycle before a wait)
//   i_en      : count this cycle (asserted while waiting)
//   o_expire  : high in the TMO-th consecutive enabled cycle
// -----------------------------------------------------------------------------
module qq_fill_wdog #(
    parameter int TMO = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);
    localparam int CW = $clog2(TMO + 1);

    logic [CW-1:0] r_cnt;

    // Count holds at TMO so a stalled enable can never wrap back to expiry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != CW'(TMO))) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // r_cnt is 0 in the first enabled cycle, so TMO-1 marks the TMO-th one.
    assign o_expire = i_en && (r_cnt == CW'(TMO - 1));
endmodule

// File: rtl/qq_fill_ctrl.sv
// -----------------------------------------------------------------------------
// qq_fill_ctrl: fill sequencer for the Quick Priority Queue. On a refill
// request it reads up to FILL_N keys from the lower-level key store, one at a
// time, and writes them into top-bank slots 0..2, pulsing the fill counter per
// write and ending the burst on the counter's cnt_done.
//   clk, rst : clock, async active-high reset
//   bus      : qq_fill_ctrl_if.master (request, store read, bank write,
//              fill counter)
//   o_state  : current sequencer state, for observation
// Optional: define QQ_FILL_TIMEOUT_EN to abort a read that gets no rd_valid
// within TMO cycles (fill_err=1); otherwise the read waits indefinitely.
// -----------------------------------------------------------------------------
module qq_fill_ctrl
    import qq_pkg::*;
#(
    parameter int KW     = KW_DEF,
    parameter int AW     = AW_DEF,
    parameter int SLOT_W = 2,
    parameter int TMO    = 15
) (
    input  logic           clk,
    input  logic           rst,
    qq_fill_ctrl_if.master bus,
    output fill_state_t    o_state
);
    fill_state_t       r_state;
    fill_state_t       w_next;
    logic [AW-1:0]     r_addr;
    logic [SLOT_W-1:0] r_offset;
    logic [KW-1:0]     r_data;
    logic              r_short;
    logic              r_err;
    logic              r_last;   // the write at the final slot has happened

    logic w_ack, w_done, w_rd_en, w_wr_en, w_fill_rst, w_expire;

`ifdef QQ_FILL_TIMEOUT_EN
    qq_fill_wdog #(.TMO(TMO)) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (r_state == REQ),
        .i_en     (r_state == WAIT),
        .o_expire (w_expire)
    );
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TMO > 0);
    assign w_expire     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // IDLE's accept is gated by rst: the state is forced to IDLE while rst is
    // high and a pending fill_req must not leak out as ack/fill_rst then.
    always_comb begin
        w_next     = r_state;
        w_ack      = 1'b0;
        w_done     = 1'b0;
        w_rd_en    = 1'b0;
        w_wr_en    = 1'b0;
        w_fill_rst = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.fill_req && !rst) begin
                    w_ack      = 1'b1;
                    w_fill_rst = 1'b1;
                    w_next     = REQ;
                end
            end
            REQ: begin
                w_rd_en = 1'b1;
                w_next  = WAIT;
            end
            WAIT: begin
                if (bus.rd_valid) w_next = bus.rd_empty ? DONE : WRITE;
                else if (w_expire) w_next = DONE;
            end
            WRITE: begin
                w_wr_en = 1'b1;
                w_next  = CHECK;
            end
            CHECK: begin
                // A missing cnt_done after the last slot is a counter fault.
                if (bus.cnt_done || r_last) w_next = DONE;
                else                        w_next = REQ;
            end
            DONE: begin
                w_done     = 1'b1;
                w_fill_rst = 1'b1;
                w_next     = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr   <= '0;
            r_offset <= '0;
            r_data   <= '0;
            r_short  <= 1'b0;
            r_err    <= 1'b0;
            r_last   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.fill_req) begin
                        r_addr   <= bus.fill_base;
                        r_offset <= '0;
                        r_short  <= 1'b0;
                        r_err    <= 1'b0;
                        r_last   <= 1'b0;
                    end
                end
                WAIT: begin
                    if (bus.rd_valid) begin
                        if (bus.rd_empty) r_short <= 1'b1;
                        else              r_data  <= bus.rd_data;
                    end else if (w_expire) begin
                        r_err <= 1'b1;
                    end
                end
                WRITE: begin
                    r_addr <= r_addr + AW'(1);
                    if (r_offset == SLOT_W'(FILL_N - 1)) r_last <= 1'b1;
                    else                                 r_offset <= r_offset + SLOT_W'(1);
                end
                CHECK: begin
                    if (!bus.cnt_done && r_last) r_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.fill_ack   = w_ack;
    assign bus.fill_done  = w_done;
    assign bus.fill_short = w_done & r_short;
    assign bus.fill_err   = w_done & r_err;
    assign bus.rd_en      = w_rd_en;
    assign bus.rd_addr    = w_rd_en ? r_addr : '0;
    assign bus.wr_en      = w_wr_en;
    assign bus.wr_slot    = w_wr_en ? r_offset : '0;
    assign bus.wr_data    = w_wr_en ? r_data : '0;
    assign bus.fill_cnt   = w_wr_en;
    assign bus.fill_rst   = w_fill_rst;
    assign o_state        = r_state;
endmodule
